// File: rtl/dmem_defs.sv
// Shared definitions for the data memory port: FSM state encodings and word geometry.
package dmem_defs;

  typedef enum logic [1:0] {
    DM_IDLE = 2'b00,
    DM_RD   = 2'b01,
    DM_WR   = 2'b10,
    DM_DONE = 2'b11
  } dm_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Big-endian lane pick: lane 0 is bits [31:24], lane 3 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide RAM: combinational read, synchronous write. Contents are never reset.
module byte_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  assign rdata = mem[addr];

  // Write the addressed byte on the access edge.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/data_mem_port.sv
// Responder for the control unit's mRD/mWR strobes: serves 32-bit word loads/stores through
// a byte-wide RAM, one byte per beat, big-endian, with optional wait cycles per beat.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (reject word accesses with DAddr[1:0] != 0).
module data_mem_port
  import dmem_defs::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        misalign
);

  localparam logic [2:0] WAIT_LAST = WAIT_CYC[2:0];

  dm_state_t         state, state_nx;
  logic              armed;
  logic [1:0]        beat;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic              req, accept, access, last_beat, bad_align;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;

  // Upper address bits are deliberately not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^DAddr[31:ADDR_W];

  assign req       = mRD | mWR;
  assign accept    = (state == DM_IDLE) && armed && req;
  assign access    = ((state == DM_RD) || (state == DM_WR)) && (wait_cnt == WAIT_LAST);
  assign last_beat = access && (beat == 2'(BYTES_PER_WORD - 1));

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  assign bad_align = (DAddr[1:0] != 2'b00);
  assign misalign  = (state == DM_DONE) && mis_q;

  // Remember whether the accepted request was rejected for alignment.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)      mis_q <= 1'b0;
    else if (accept) mis_q <= bad_align;
  end
`else
  assign bad_align = 1'b0;
  assign misalign  = 1'b0;
`endif

  assign mem_ready = (state == DM_DONE);
  assign mem_busy  = (state != DM_IDLE);

  assign ram_we    = access && (state == DM_WR);
  assign ram_addr  = addr_q + ADDR_W'(beat);
  assign ram_wdata = word_byte(wdata_q, beat);

  byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= DM_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a write wins when both strobes are high.
  always_comb begin
    state_nx = state;
    case (state)
      DM_IDLE: begin
        if (accept) begin
          if (bad_align)  state_nx = DM_DONE;
          else if (mWR)   state_nx = DM_WR;
          else            state_nx = DM_RD;
        end
      end
      DM_RD, DM_WR: begin
        if (last_beat) state_nx = DM_DONE;
      end
      default: state_nx = DM_IDLE;
    endcase
  end

  // Control: arming, beat/wait counters and the load result register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      armed    <= 1'b1;
      beat     <= 2'd0;
      wait_cnt <= 3'd0;
      DataOut  <= 32'd0;
    end else begin
      // Re-arm only after both strobes are seen low in IDLE, so a held strobe runs once.
      if (state == DM_IDLE) begin
        if (!req)       armed <= 1'b1;
        else if (armed) armed <= 1'b0;
      end
      if (accept) begin
        beat     <= 2'd0;
        wait_cnt <= 3'd0;
      end else if ((state == DM_RD) || (state == DM_WR)) begin
        if (access) begin
          wait_cnt <= 3'd0;
          beat     <= beat + 2'd1;
        end else begin
          wait_cnt <= wait_cnt + 3'd1;
        end
      end
      // Publish the whole word at once, with the final byte taken straight from the RAM.
      if (last_beat && (state == DM_RD)) DataOut <= {asm_q[31:8], ram_rdata};
    end
  end

  // Request capture and read assembly (datapath, not reset).
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= DAddr[ADDR_W-1:0];
      wdata_q <= DataIn;
    end
    if (access && (state == DM_RD)) begin
      case (beat)
        2'd0:    asm_q[31:24] <= ram_rdata;
        2'd1:    asm_q[23:16] <= ram_rdata;
        2'd2:    asm_q[15:8]  <= ram_rdata;
        default: asm_q[7:0]   <= ram_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: two instances (WAIT_CYC=0 and WAIT_CYC=2) checked
// against a byte-array reference model of the RAM and the load register.
module tb_data_mem_port;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        rd0 = 0, wr0 = 0;
  logic [31:0] addr0 = 0, din0 = 0;
  logic [31:0] dout0;
  logic        rdy0, busy0, mis0;

  logic        rd2 = 0, wr2 = 0;
  logic [31:0] addr2 = 0, din2 = 0;
  logic [31:0] dout2;
  logic        rdy2, busy2, mis2;

  bit          sel = 1'b0;
  logic [31:0] cur_dout;
  logic        cur_rdy, cur_busy, cur_mis;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ref0 [256];
  logic [7:0]  ref2 [256];
  logic [31:0] rdout0 = 32'd0;
  logic [31:0] rdout2 = 32'd0;

  always #5 clk = ~clk;

  data_mem_port #(.ADDR_W(8), .WAIT_CYC(0)) dut (
    .CLK(clk), .Reset(rst_n), .mRD(rd0), .mWR(wr0), .DAddr(addr0), .DataIn(din0),
    .DataOut(dout0), .mem_ready(rdy0), .mem_busy(busy0), .misalign(mis0)
  );

  data_mem_port #(.ADDR_W(8), .WAIT_CYC(2)) dut_slow (
    .CLK(clk), .Reset(rst_n), .mRD(rd2), .mWR(wr2), .DAddr(addr2), .DataIn(din2),
    .DataOut(dout2), .mem_ready(rdy2), .mem_busy(busy2), .misalign(mis2)
  );

  assign cur_dout = sel ? dout2 : dout0;
  assign cur_rdy  = sel ? rdy2  : rdy0;
  assign cur_busy = sel ? busy2 : busy0;
  assign cur_mis  = sel ? mis2  : mis0;

  function automatic logic [31:0] model_word(input bit s, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  idx;
    for (int i = 0; i < 4; i++) begin
      idx = a[7:0] + 8'(i);
      w[31-8*i -: 8] = s ? ref2[idx] : ref0[idx];
    end
    return w;
  endfunction

  task automatic model_write(input bit s, input logic [31:0] a, input logic [31:0] d, input int nbytes);
    logic [7:0] idx;
    for (int i = 0; i < nbytes; i++) begin
      idx = a[7:0] + 8'(i);
      if (s) ref2[idx] = d[31-8*i -: 8];
      else   ref0[idx] = d[31-8*i -: 8];
    end
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin rd2 = r; wr2 = w; addr2 = a; din2 = d; end
    else     begin rd0 = r; wr0 = w; addr0 = a; din0 = d; end
  endtask

  // One complete transaction on the selected instance, with strobes held for 'hold' cycles.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int hold, input string tag);
    bit          mis_exp;
    int          lat_exp, limit, first, pulses;
    logic        mis_seen, busy_first, busy_ready, early_change;
    logic [31:0] old, dout_exp, dout_ready;
    mis_exp  = ALIGN_EN && (a[1:0] != 2'b00);
    lat_exp  = mis_exp ? 1 : 4 * (1 + (sel ? 2 : 0)) + 1;
    old      = sel ? rdout2 : rdout0;
    dout_exp = (r && !w && !mis_exp) ? model_word(sel, a) : old;
    @(negedge clk); set_req(1'b0, 1'b0, a, d);
    @(negedge clk);
    @(negedge clk); set_req(r, w, a, d);
    limit = ((lat_exp > hold) ? lat_exp : hold) + 3;
    first = -1; pulses = 0; mis_seen = 1'bx; busy_first = 1'b0; busy_ready = 1'b0;
    early_change = 1'b0; dout_ready = 32'hx;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) busy_first = cur_busy;
      if (n >= hold) set_req(1'b0, 1'b0, a, d);
      if (cur_rdy === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = n; mis_seen = cur_mis; busy_ready = cur_busy; dout_ready = cur_dout;
        end
      end else if (first < 0 && cur_dout !== old) begin
        early_change = 1'b1;
      end
    end
    checks++; if (first !== lat_exp) begin failures++; $display("FAIL %s latency got %0d want %0d", tag, first, lat_exp); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL %s ready_pulses got %0d want 1", tag, pulses); end
    checks++; if (mis_seen !== mis_exp) begin failures++; $display("FAIL %s misalign got %b want %b", tag, mis_seen, mis_exp); end
    checks++; if (busy_first !== 1'b1 || busy_ready !== 1'b1) begin failures++; $display("FAIL %s busy got %b/%b want 1/1", tag, busy_first, busy_ready); end
    checks++; if (dout_ready !== dout_exp) begin failures++; $display("FAIL %s dataout got %h want %h", tag, dout_ready, dout_exp); end
    checks++; if (early_change !== 1'b0) begin failures++; $display("FAIL %s partial_dataout got %b want 0", tag, early_change); end
    checks++; if (cur_busy !== 1'b0) begin failures++; $display("FAIL %s busy_after got %b want 0", tag, cur_busy); end
    if (w && !mis_exp) model_write(sel, a, d, 4);
    if (sel) rdout2 = dout_exp; else rdout0 = dout_exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dout0 !== 32'd0) begin failures++; $display("FAIL reset_dataout got %h want 0", dout0); end
    checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b0 || mis0 !== 1'b0) begin failures++; $display("FAIL reset_flags got %b%b%b want 000", rdy0, busy0, mis0); end
    checks++; if (dout2 !== 32'd0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_slow got %h/%b want 0/0", dout2, busy2); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    sel = 1'b0;
    for (int i = 0; i < 64; i++) run_access(1'b0, 1'b1, 32'(i * 4), $urandom, 1, "fill");
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_access(1'b0, 1'b1, 32'h10, 32'h12345678, 1, "sw_0x10");
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 1, "lw_0x10");
    run_access(1'b1, 1'b0, 32'h11, 32'h0, 1, "lw_0x11");
  endtask

  task automatic test_wrap();
    sel = 1'b0;
    run_access(1'b0, 1'b1, 32'hFE, 32'hAABBCCDD, 1, "sw_wrap");
    run_access(1'b1, 1'b0, 32'hFC, 32'h0, 1, "lw_top");
    run_access(1'b1, 1'b0, 32'h00, 32'h0, 1, "lw_bottom");
  endtask

  task automatic test_both_strobes();
    sel = 1'b0;
    run_access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 10, "both_held");
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 1, "lw_after_both");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    sel = 1'b0;
    d = $urandom;
    @(negedge clk); set_req(1'b0, 1'b0, 32'h30, d);
    @(negedge clk);
    @(negedge clk); set_req(1'b0, 1'b1, 32'h30, d);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h30, d);
    rst_n = 1'b0;
    #1;
    checks++; if (dout0 !== 32'd0 || rdy0 !== 1'b0 || busy0 !== 1'b0 || mis0 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_outputs got %h %b%b%b want 0 000", dout0, rdy0, busy0, mis0);
    end
    model_write(1'b0, 32'h30, d, 2);
    rdout0 = 32'd0;
    rdout2 = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b1, 1'b0, 32'h30, 32'h0, 1, "lw_after_abort");
  endtask

  task automatic test_wait_and_align();
    sel = 1'b1;
    run_access(1'b0, 1'b1, 32'h40, $urandom, 1, "slow_sw");
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 1, "slow_lw");
    sel = 1'b0;
    run_access(1'b1, 1'b0, 32'h42, 32'h0, 1, "lw_0x42");
  endtask

  task automatic test_random();
    int op;
    sel = 1'b0;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      run_access(op != 1, op != 0, 32'($urandom_range(0, 255)), $urandom,
                 $urandom_range(1, 3), "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_wrap();
    test_both_strobes();
    test_reset_mid();
    test_wait_and_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
